// File: rtl/pps_pkg.sv
// Shared types and reset-default helpers for the PPS/blink channel bank.
package pps_pkg;

  // Config fields are carried at a fixed wide width and zero-extended from the
  // channel's CW-bit values, so one struct type serves every CW up to 64.
  localparam int PPS_CFG_W = 64;

  typedef struct packed {
    logic                 en;
    logic [PPS_CFG_W-1:0] period;  // period minus one
    logic [PPS_CFG_W-1:0] high;    // high-time in cycles
  } pps_cfg_t;

  function automatic logic [PPS_CFG_W-1:0] dflt_period(input longint rate);
    return PPS_CFG_W'(rate - 64'sd1);
  endfunction

  function automatic logic [PPS_CFG_W-1:0] dflt_high(input longint rate);
    return PPS_CFG_W'(rate / 64'sd2);
  endfunction

  // Reset config: enabled, 1 Hz period, 50 % duty.
  function automatic pps_cfg_t dflt_cfg(input longint rate);
    pps_cfg_t c;
    c.en     = 1'b1;
    c.period = dflt_period(rate);
    c.high   = dflt_high(rate);
    return c;
  endfunction

endpackage

// File: rtl/pps_chan.sv
// One blink/PPS channel: active and pending config, period counter,
// registered LED level and one-cycle wrap strobe.
module pps_chan
  import pps_pkg::*;
#(
  parameter int CLOCK_RATE_HZ = 50_000_000,
  parameter int CW            = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr,
  input  logic          i_wr_en,
  input  logic [CW-1:0] i_wr_period,
  input  logic [CW-1:0] i_wr_high,
  input  logic          i_sync,
  output logic          o_led,
  output logic          o_pps
);

  pps_cfg_t      act_q, act_d;
  pps_cfg_t      pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;
  logic          pps_q, pps_d;
  pps_cfg_t      wr_cfg;
  logic          wrap;

  assign wr_cfg.en     = i_wr_en;
  assign wr_cfg.period = PPS_CFG_W'(i_wr_period);
  assign wr_cfg.high   = PPS_CFG_W'(i_wr_high);

  // Counter never exceeds the period, so equality marks the last cycle.
  assign wrap = act_q.en && (PPS_CFG_W'(cnt_q) == act_q.period);

  // Next-state: count/wrap, pending hand-over at wrap or sync, write capture.
  always_comb begin
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    if (act_q.en) begin
      if (i_sync || wrap) begin
        cnt_d = '0;
        if (pend_vld_q) begin
          act_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // A write lands after any hand-over this cycle, so it stays pending.
      if (i_wr) begin
        pend_d     = wr_cfg;
        pend_vld_d = 1'b1;
      end
    end else begin
      cnt_d = '0;
      if (i_wr) begin
        act_d      = wr_cfg;
        pend_vld_d = 1'b0;
      end
    end
    // Outputs reflect the post-edge state: a channel disabled at its wrap
    // emits no strobe, and sync suppresses the strobe entirely.
    led_d = act_d.en && (PPS_CFG_W'(cnt_d) < act_d.high);
    pps_d = wrap && act_d.en && !i_sync;
  end

  // State registers with asynchronous restore of the 1 Hz defaults.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      act_q      <= dflt_cfg(longint'(CLOCK_RATE_HZ));
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      led_q      <= 1'b0;
      pps_q      <= 1'b0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
      pps_q      <= pps_d;
    end
  end

  assign o_led = led_q;
  assign o_pps = pps_q;

endmodule

// File: rtl/pps_bank.sv
// Bank of NCH independent blink/PPS channels with a shared config write port.
// Optional feature: define PPS_BANK_SYNC_EN to make i_sync phase-align all
// channels; otherwise i_sync is present but ignored.
module pps_bank
  import pps_pkg::*;
#(
  parameter int CLOCK_RATE_HZ = 50_000_000,
  parameter int NCH           = 4,
  parameter int CW            = 32
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset_n,
  input  logic                                    i_wr,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] i_wr_ch,
  input  logic                                    i_wr_en,
  input  logic [CW-1:0]                           i_wr_period,
  input  logic [CW-1:0]                           i_wr_high,
  input  logic                                    i_sync,
  output logic [NCH-1:0]                          o_led,
  output logic [NCH-1:0]                          o_pps
);

  logic           sync_s;
  logic [NCH-1:0] wr_sel;

`ifdef PPS_BANK_SYNC_EN
  assign sync_s = i_sync;
`else
  logic unused_sync;
  assign unused_sync = i_sync;
  assign sync_s      = 1'b0;
`endif

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    // Indices at or beyond NCH match no channel, so such writes drop out.
    assign wr_sel[ch] = i_wr && (int'(i_wr_ch) == ch);

    pps_chan #(
      .CLOCK_RATE_HZ(CLOCK_RATE_HZ),
      .CW           (CW)
    ) u_chan (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_wr       (wr_sel[ch]),
      .i_wr_en    (i_wr_en),
      .i_wr_period(i_wr_period),
      .i_wr_high  (i_wr_high),
      .i_sync     (sync_s),
      .o_led      (o_led[ch]),
      .o_pps      (o_pps[ch])
    );
  end

endmodule

// File: tb/tb_pps_bank.sv
// Directed, table-driven bench for pps_bank (CLOCK_RATE_HZ=10, NCH=5).
module tb_pps_bank;

  localparam int RATE = 10;
  localparam int NCH  = 5;
  localparam int CW   = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr = 1'b0;
  logic [2:0]     wr_ch = '0;
  logic           wr_en = 1'b0;
  logic [CW-1:0]  wr_period = '0;
  logic [CW-1:0]  wr_high = '0;
  logic           sync = 1'b0;
  logic [NCH-1:0] led;
  logic [NCH-1:0] pps;

  always #5 clk = ~clk;

  pps_bank #(.CLOCK_RATE_HZ(RATE), .NCH(NCH), .CW(CW)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_wr       (wr),
    .i_wr_ch    (wr_ch),
    .i_wr_en    (wr_en),
    .i_wr_period(wr_period),
    .i_wr_high  (wr_high),
    .i_sync     (sync),
    .o_led      (led),
    .o_pps      (pps)
  );

  typedef struct {
    logic wr;
    int   ch;
    logic en;
    int   per;
    int   high;
    logic sync;
    int   chk;
    logic exp_led;
    logic exp_pps;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0h want %0h", name, n, act, exp);
    end
  endtask

  function automatic void push(input logic w, input int ch, input logic en, input int per,
                               input int high, input logic s, input int chk,
                               input logic l, input logic p);
    vec_t v;
    v.wr = w; v.ch = ch; v.en = en; v.per = per; v.high = high; v.sync = s;
    v.chk = chk; v.exp_led = l; v.exp_pps = p;
    tbl.push_back(v);
  endfunction

  function automatic void idle(input int chk, input logic l, input logic p);
    push(1'b0, 0, 1'b0, 0, 0, 1'b0, chk, l, p);
  endfunction

  function automatic void wrv(input int ch, input logic en, input int per, input int high,
                              input int chk, input logic l, input logic p);
    push(1'b1, ch, en, per, high, 1'b0, chk, l, p);
  endfunction

  task automatic drive(input logic w, input int ch, input logic en, input int per,
                       input int high, input logic s);
    wr        = w;
    wr_ch     = 3'(ch);
    wr_en     = en;
    wr_period = CW'(per);
    wr_high   = CW'(high);
    sync      = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Default-config expectation, n edges after reset release.
  function automatic logic def_led(input int e);
    return (e % RATE) < (RATE / 2);
  endfunction

  function automatic logic def_pps(input int e);
    return (e > 0) && ((e % RATE) == 0);
  endfunction

  initial begin
    // ch1: write at C=5, overwritten before the wrap; old period completes.
    for (int e = 21; e <= 24; e++) idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);                       // 25: C=5
    wrv(1, 1'b1, 7, 2, 1, 1'b0, 1'b0);         // 26
    wrv(1, 1'b1, 3, 1, 1, 1'b0, 1'b0);         // 27: overwrites pending
`ifdef PPS_BANK_SYNC_EN
    idle(1, 1'b0, 1'b0);                       // 28
`else
    push(1'b0, 0, 1'b0, 0, 0, 1'b1, 1, 1'b0, 1'b0); // 28: sync ignored
`endif
    idle(1, 1'b0, 1'b0);                       // 29
    for (int r = 0; r < 2; r++) begin          // 30..37
      idle(1, 1'b1, 1'b1);
      idle(1, 1'b0, 1'b0);
      idle(1, 1'b0, 1'b0);
      idle(1, 1'b0, 1'b0);
    end
    idle(1, 1'b1, 1'b1);                       // 38
    // ch2: disable (applied at wrap), then enable with P=0,H=1.
    wrv(2, 1'b0, 9, 5, 2, 1'b0, 1'b0);         // 39
    for (int e = 40; e <= 42; e++) idle(2, 1'b0, 1'b0);
    wrv(2, 1'b1, 0, 1, 2, 1'b1, 1'b0);         // 43
    for (int e = 44; e <= 46; e++) idle(2, 1'b1, 1'b1);
    // ch3: H > P gives constant high, then H=0 gives constant low.
    wrv(3, 1'b1, 9, 20, 3, 1'b0, 1'b0);        // 47
    idle(3, 1'b0, 1'b0);                       // 48
    idle(3, 1'b0, 1'b0);                       // 49
    idle(3, 1'b1, 1'b1);                       // 50
    for (int e = 51; e <= 59; e++) idle(3, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);                       // 60
    wrv(3, 1'b1, 9, 0, 3, 1'b1, 1'b0);         // 61
    for (int e = 62; e <= 69; e++) idle(3, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);                       // 70
    // Write to channel index NCH is dropped.
    wrv(5, 1'b0, 0, 0, 3, 1'b0, 1'b0);         // 71
    idle(3, 1'b0, 1'b0);                       // 72
    idle(1, 1'b0, 1'b0);                       // 73
    idle(1, 1'b1, 1'b1);                       // 74

    // Reset state.
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_pps", 32'(pps), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    // Defaults, no writes.
    for (int e = 1; e <= 20; e++) begin
      tick();
      check("dflt_led", 32'(led), def_led(n) ? 32'h1f : 32'h0);
      check("dflt_pps", 32'(pps), def_pps(n) ? 32'h1f : 32'h0);
    end

    // Table: target channel plus untouched ch0 every cycle.
    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].ch, tbl[i].en, tbl[i].per, tbl[i].high, tbl[i].sync);
      tick();
      check($sformatf("ch%0d_led", tbl[i].chk), 32'(led[tbl[i].chk]), 32'(tbl[i].exp_led));
      check($sformatf("ch%0d_pps", tbl[i].chk), 32'(pps[tbl[i].chk]), 32'(tbl[i].exp_pps));
      check("ch0_led", 32'(led[0]), 32'(def_led(n)));
      check("ch0_pps", 32'(pps[0]), 32'(def_pps(n)));
    end

`ifdef PPS_BANK_SYNC_EN
    // Sync: all counters to 0, strobes suppressed, then aligned.
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1);
    tick();
    check("sync_led", 32'(led), 32'b10111);
    check("sync_pps", 32'(pps), 32'd0);
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      logic [NCH-1:0] exp_p;
      tick();
      exp_p = 5'b00100;
      if (k % 4 == 0)  exp_p = exp_p | 5'b00010;
      if (k % 10 == 0) exp_p = exp_p | 5'b11001;
      check("post_sync_pps", 32'(pps), 32'(exp_p));
    end
`endif

    // Reset mid-period with a pending write on ch1.
    drive(1'b1, 1, 1'b1, 1, 1, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_pps", 32'(pps), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      check("rerst_led", 32'(led), def_led(n) ? 32'h1f : 32'h0);
      check("rerst_pps", 32'(pps), def_pps(n) ? 32'h1f : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pps_bank.md
PPS_BANK -- requirements
Module: pps_bank

Interface
REQ-001 SHALL have parameter CLOCK_RATE_HZ, default 50_000_000, input clock frequency; reset-default period is CLOCK_RATE_HZ cycles.
REQ-002 SHALL have parameter NCH, default 4, number of independent blink/PPS channels (1..16).
REQ-003 SHALL have parameter CW, default 32, counter/period/high-time width in bits.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_wr, input, 1, single-cycle config write strobe.
REQ-007 SHALL have port i_wr_ch, input, $clog2(NCH) (min 1), target channel of write.
REQ-008 SHALL have port i_wr_en, input, 1, channel enable value written.
REQ-009 SHALL have port i_wr_period, input, CW, period minus one (P) written.
REQ-010 SHALL have port i_wr_high, input, CW, high-time in cycles (H) written.
REQ-011 SHALL have port i_sync, input, 1, phase-align strobe for all channels.
REQ-012 SHALL have port o_led, output, NCH, per-channel duty-cycled level.
REQ-013 SHALL have port o_pps, output, NCH, per-channel one-cycle strobe at period wrap.

Function
REQ-014 Each channel SHALL hold an active set (EN, P, H), a pending set, a pending flag and a CW-bit counter C.
REQ-015 Enabled channel: C SHALL increment each cycle and wrap to 0 on the cycle after C == P (period P+1 cycles); invariant C <= P always.
REQ-016 o_led[ch] SHALL be registered, equal EN && (C < H); H > P gives constant high, H == 0 constant low.
REQ-017 o_pps[ch] SHALL be high for exactly the one cycle in which the wrap C -> 0 is registered, only when EN.
REQ-018 Write to an enabled channel SHALL load the pending set; pending SHALL be copied to active at the next wrap (glitch-free), with a later write before the wrap overwriting the pending set.
REQ-019 Write to a disabled channel SHALL take effect on the next cycle: active set loaded, C = 0, pending cleared.
REQ-020 Disabled channel: C held at 0, o_led = 0, o_pps = 0.
REQ-021 P == 0: C stays 0, o_pps high every cycle while EN, o_led = (H != 0).
REQ-022 Writes to i_wr_ch >= NCH SHALL be ignored.
REQ-023 Arithmetic SHALL be unsigned CW-bit; counter never exceeds P so no overflow wrap occurs.
REQ-024 Channels SHALL be fully independent except for i_sync.

Reset
REQ-025 On i_reset_n low, immediately and asynchronously: C = 0, EN = 1, P = CLOCK_RATE_HZ-1, H = CLOCK_RATE_HZ/2, pending cleared, o_led = 0, o_pps = 0.
REQ-026 First wrap after reset release SHALL occur CLOCK_RATE_HZ cycles after the first active edge; reset mid-period SHALL discard pending writes.

Configuration
REQ-027 With macro PPS_BANK_SYNC_EN defined, i_sync high SHALL, next cycle, set C = 0 in all channels, apply any pending set, and suppress o_pps for that cycle; i_sync outranks a coincident wrap, and a coincident write to the same channel lands in pending (enabled) or active (disabled) after the sync.
REQ-028 Without PPS_BANK_SYNC_EN, i_sync port SHALL exist and be ignored.

Structure
REQ-029 Shared package pps_pkg SHALL hold the channel config struct type (en, period, high) and the default-derivation constants.
REQ-030 A sub-module pps_chan SHALL implement one channel; pps_bank SHALL hold write decode and NCH instances.

Verification
REQ-031 Reset, CLOCK_RATE_HZ=10, no writes -> o_pps ch0 every 10 cycles, o_led high 5 and low 5 cycles.
REQ-032 Write ch1 P=3,H=1 at C=5 of a 10-cycle period -> old period completes, then o_pps every 4 cycles, o_led 1 high/3 low.
REQ-033 Write ch2 en=0, then en=1,P=0,H=1 -> outputs 0 while disabled; then o_pps and o_led high every cycle.
REQ-034 Write ch3 H=20,P=9 -> o_led constantly high, o_pps every 10 cycles; H=0 -> o_led constantly low.
REQ-035 PPS_BANK_SYNC_EN, channels at differing phases, pulse i_sync -> all C=0 next cycle, no o_pps that cycle, subsequent o_pps coincident.
REQ-036 Assert i_reset_n low mid-period with pending write -> outputs 0 at once, defaults restored, pending write lost; write to ch index NCH -> no effect.
